// File: rtl/yonga_lz4_pkg.sv
// ---------------------------------------------------------------------------
// yonga_lz4_pkg
//   Shared definitions for the LZ4 sequence encoder: the encoder FSM state
//   type and the LZ4 format constants used for token nibbles and length
//   extension bytes.
// ---------------------------------------------------------------------------
package yonga_lz4_pkg;

    // Shortest match LZ4 can express; the token stores match_len - MIN_MATCH.
    localparam int unsigned MIN_MATCH    = 4;
    // A saturated token nibble signals that extension bytes follow.
    localparam int unsigned NIBBLE_MAX   = 15;
    // Extension bytes of this value mean "add 255 and keep reading".
    localparam int unsigned EXT_BYTE_MAX = 255;

    // Encoder state: each state names the byte class the output register
    // is currently producing, TOKEN being a one-cycle dispatch step.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TOKEN   = 3'd1,
        ST_LIT_EXT = 3'd2,
        ST_LITS    = 3'd3,
        ST_OFF_LO  = 3'd4,
        ST_OFF_HI  = 3'd5,
        ST_ML_EXT  = 3'd6
    } enc_state_e;

endpackage

// File: rtl/yonga_lz4_len_ext_gen.sv
// ---------------------------------------------------------------------------
// yonga_lz4_len_ext_gen
//   Produces the LZ4 length extension byte sequence for a length L >= 15:
//   a run of 8'hFF bytes while the remainder is >= 255, then the final
//   remainder byte (which may be 8'h00).
//
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   load_i  - capture len_i; remainder becomes len_i - 15
//   len_i   - length to encode (only meaningful when >= 15)
//   step_i  - current byte has been emitted, advance to the next one
//   byte_o  - current extension byte
//   done_o  - current byte is the final extension byte
// ---------------------------------------------------------------------------
module yonga_lz4_len_ext_gen
    import yonga_lz4_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             step_i,
    output logic [7:0]       byte_o,
    output logic             done_o
);

    logic [LEN_W-1:0] rem_q;
    logic [LEN_W-1:0] rem_d;
    logic             remBig;

    assign remBig = (rem_q >= LEN_W'(EXT_BYTE_MAX));
    assign byte_o = remBig ? 8'hFF : rem_q[7:0];
    assign done_o = !remBig;

    // The remainder only ever drops by 255 while it is at least 255, so it
    // can never wrap; stepping on the final byte leaves it unchanged.
    always_comb begin
        rem_d = rem_q;
        if (load_i) begin
            rem_d = len_i - LEN_W'(NIBBLE_MAX);
        end else if (step_i && remBig) begin
            rem_d = rem_q - LEN_W'(EXT_BYTE_MAX);
        end
    end

    // Remainder register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/yonga_lz4_sequence_encoder.sv
// ---------------------------------------------------------------------------
// yonga_lz4_sequence_encoder
//   Serializes LZ4 sequence commands (literal length, match length, offset)
//   plus a literal byte stream into an LZ4 block byte stream:
//   token, literal-length extension, literals, offset (LE), match-length
//   extension.
//
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   seq_valid/seq_ready           - command handshake
//   lit_len, match_len, offset    - command fields (match_len 0 when last)
//   seq_last                      - final, literals-only sequence of block
//   lit_valid/lit_ready/lit_data  - literal byte stream
//   out_valid/out_ready/out_data  - encoded byte stream
//   out_last                      - final byte of the block
//   busy                          - sequence in flight or byte pending
//   err                           - one-cycle pulse on an illegal command
// ---------------------------------------------------------------------------
module yonga_lz4_sequence_encoder
    import yonga_lz4_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seq_valid,
    output logic             seq_ready,
    input  logic [LEN_W-1:0] lit_len,
    input  logic [LEN_W-1:0] match_len,
    input  logic [15:0]      offset,
    input  logic             seq_last,
    input  logic             lit_valid,
    output logic             lit_ready,
    input  logic [7:0]       lit_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_data,
    output logic             out_last,
    output logic             busy,
    output logic             err
);

    enc_state_e       state_q;
    logic             active_q;
    logic [LEN_W-1:0] litRem_q;
    logic [15:0]      offset_q;
    logic             seqLast_q;
    logic             litExt_q;
    logic             hasLits_q;
    logic             mlExt_q;
    logic             outValid_q;
    logic             outLast_q;
    logic [7:0]       outData_q;
    logic             err_q;

    logic             loadOk;
    logic             accept;
    logic             cmdBad;
    logic [LEN_W-1:0] mlMinus;
    logic             litExtNeed;
    logic             mlExtNeed;
    logic [3:0]       litNib;
    logic [3:0]       mlNib;
    logic             litFire;
    logic             genLoad;
    logic             litExtStep;
    logic             mlExtStep;
    logic [7:0]       litExtByte;
    logic             litExtDone;
    logic [7:0]       mlExtByte;
    logic             mlExtDone;

    // The output register can take a new byte when it is empty or its
    // current byte is being taken this cycle. active_q keeps both ready
    // outputs low while reset is asserted.
    assign loadOk    = !outValid_q || out_ready;
    assign seq_ready = active_q && (state_q == ST_IDLE) && loadOk;
    assign lit_ready = active_q && (state_q == ST_LITS) && loadOk;
    assign accept    = seq_valid && seq_ready;
    assign litFire   = lit_valid && lit_ready;

    assign cmdBad = seq_last ? (match_len != '0)
                             : ((match_len < LEN_W'(MIN_MATCH)) || (offset == 16'h0000));

    // Token nibbles and extension decisions, evaluated on the raw command so
    // the token can be loaded on the accept edge. mlMinus may wrap for last
    // sequences; it is masked there by seq_last.
    assign mlMinus    = match_len - LEN_W'(MIN_MATCH);
    assign litExtNeed = (lit_len >= LEN_W'(NIBBLE_MAX));
    assign mlExtNeed  = !seq_last && (mlMinus >= LEN_W'(NIBBLE_MAX));
    assign litNib     = litExtNeed ? 4'hF : lit_len[3:0];
    assign mlNib      = seq_last ? 4'h0 : (mlExtNeed ? 4'hF : mlMinus[3:0]);

    assign genLoad    = accept && !cmdBad;
    assign litExtStep = (state_q == ST_LIT_EXT) && loadOk;
    assign mlExtStep  = (state_q == ST_ML_EXT) && loadOk;

    yonga_lz4_len_ext_gen #(.LEN_W(LEN_W)) u_lit_ext (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .load_i (genLoad),
        .len_i  (lit_len),
        .step_i (litExtStep),
        .byte_o (litExtByte),
        .done_o (litExtDone)
    );

    yonga_lz4_len_ext_gen #(.LEN_W(LEN_W)) u_ml_ext (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .load_i (genLoad),
        .len_i  (mlMinus),
        .step_i (mlExtStep),
        .byte_o (mlExtByte),
        .done_o (mlExtDone)
    );

    // Encoder FSM and output register. Every state that emits a byte loads
    // it only when loadOk, so a stalled byte is never overwritten. TOKEN is
    // a dispatch cycle while the token sits in the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            active_q   <= 1'b0;
            litRem_q   <= '0;
            offset_q   <= 16'h0000;
            seqLast_q  <= 1'b0;
            litExt_q   <= 1'b0;
            hasLits_q  <= 1'b0;
            mlExt_q    <= 1'b0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            outData_q  <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            active_q <= 1'b1;
            err_q    <= 1'b0;
            if (outValid_q && out_ready) begin
                outValid_q <= 1'b0;
                outLast_q  <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (cmdBad) begin
                            err_q <= 1'b1;
                        end else begin
                            litRem_q   <= lit_len;
                            offset_q   <= offset;
                            seqLast_q  <= seq_last;
                            litExt_q   <= litExtNeed;
                            hasLits_q  <= (lit_len != '0);
                            mlExt_q    <= mlExtNeed;
                            outValid_q <= 1'b1;
                            outData_q  <= {litNib, mlNib};
                            outLast_q  <= seq_last && (lit_len == '0);
                            state_q    <= ST_TOKEN;
                        end
                    end
                end
                ST_TOKEN: begin
                    if (litExt_q) begin
                        state_q <= ST_LIT_EXT;
                    end else if (hasLits_q) begin
                        state_q <= ST_LITS;
                    end else if (seqLast_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_OFF_LO;
                    end
                end
                ST_LIT_EXT: begin
                    if (loadOk) begin
                        outValid_q <= 1'b1;
                        outData_q  <= litExtByte;
                        outLast_q  <= 1'b0;
                        if (litExtDone) begin
                            state_q <= ST_LITS;
                        end
                    end
                end
                ST_LITS: begin
                    if (litFire) begin
                        outValid_q <= 1'b1;
                        outData_q  <= lit_data;
                        outLast_q  <= seqLast_q && (litRem_q == LEN_W'(1));
                        litRem_q   <= litRem_q - LEN_W'(1);
                        if (litRem_q == LEN_W'(1)) begin
                            state_q <= seqLast_q ? ST_IDLE : ST_OFF_LO;
                        end
                    end
                end
                ST_OFF_LO: begin
                    if (loadOk) begin
                        outValid_q <= 1'b1;
                        outData_q  <= offset_q[7:0];
                        outLast_q  <= 1'b0;
                        state_q    <= ST_OFF_HI;
                    end
                end
                ST_OFF_HI: begin
                    if (loadOk) begin
                        outValid_q <= 1'b1;
                        outData_q  <= offset_q[15:8];
                        outLast_q  <= 1'b0;
                        state_q    <= mlExt_q ? ST_ML_EXT : ST_IDLE;
                    end
                end
                ST_ML_EXT: begin
                    if (loadOk) begin
                        outValid_q <= 1'b1;
                        outData_q  <= mlExtByte;
                        outLast_q  <= 1'b0;
                        if (mlExtDone) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_last  = outLast_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE) || outValid_q;

endmodule

// File: tb/tb_yonga_lz4_sequence_encoder.sv
// ---------------------------------------------------------------------------
// tb_yonga_lz4_sequence_encoder
//   Directed self-checking bench for the LZ4 sequence encoder. Each test
//   builds its hand-computed byte stream in expQ, drives one command plus
//   its literals, collects the emitted bytes and compares them.
// ---------------------------------------------------------------------------
module tb_yonga_lz4_sequence_encoder;

    localparam int LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             seq_valid = 1'b0;
    logic             seq_ready;
    logic [LEN_W-1:0] lit_len = '0;
    logic [LEN_W-1:0] match_len = '0;
    logic [15:0]      offset = 16'h0000;
    logic             seq_last = 1'b0;
    logic             lit_valid = 1'b0;
    logic             lit_ready;
    logic [7:0]       lit_data = 8'h00;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [7:0]       out_data;
    logic             out_last;
    logic             busy;
    logic             err;

    int         compareCount = 0;
    int         mismatchCount = 0;
    logic [7:0] expQ[$];
    logic [8:0] gotQ[$];
    int         expLastIdx = -1;
    bit         bpMode = 1'b0;
    bit         gapMode = 1'b0;
    int         errCycles = 0;
    bit         holdValid = 1'b0;
    logic [8:0] holdByte = '0;

    yonga_lz4_sequence_encoder #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seq_valid (seq_valid),
        .seq_ready (seq_ready),
        .lit_len   (lit_len),
        .match_len (match_len),
        .offset    (offset),
        .seq_last  (seq_last),
        .lit_valid (lit_valid),
        .lit_ready (lit_ready),
        .lit_data  (lit_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .err       (err)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Downstream ready: always accepting, or toggling every cycle under backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = bpMode ? ~out_ready : 1'b1;
        end
    end

    // Output monitor on the falling edge: records accepted bytes, counts err
    // cycles and checks a stalled byte is still presented unchanged.
    always @(negedge clk) begin
        if (!rst_n) begin
            holdValid = 1'b0;
        end else begin
            if (err) errCycles++;
            if (holdValid) begin
                checkOutput("stall_hold", {22'd0, out_valid, out_last, out_data}, {22'd0, 1'b1, holdByte});
            end
            if (out_valid && out_ready) begin
                gotQ.push_back({out_last, out_data});
                holdValid = 1'b0;
            end else if (out_valid) begin
                holdValid = 1'b1;
                holdByte  = {out_last, out_data};
            end else begin
                holdValid = 1'b0;
            end
        end
    end

    task automatic addLits(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            expQ.push_back(base + 8'(i));
        end
    endtask

    // Drive one command, then feed feedN literal bytes (base, base+1, ...).
    task automatic applyStimulus(input int litN, input int mlN, input int offN,
                                 input bit last, input int feedN, input logic [7:0] base);
        bit ok;
        @(posedge clk);
        #1;
        seq_valid = 1'b1;
        lit_len   = litN[LEN_W-1:0];
        match_len = mlN[LEN_W-1:0];
        offset    = offN[15:0];
        seq_last  = last;
        ok = 1'b0;
        for (int w = 0; w < 50 && !ok; w++) begin
            @(negedge clk);
            if (seq_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        seq_valid = 1'b0;
        if (!ok) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            return;
        end
        for (int i = 0; i < feedN; i++) begin
            if (gapMode) begin
                int g;
                lit_valid = 1'b0;
                g = $urandom_range(0, 2);
                if (g > 0) begin
                    repeat (g) @(posedge clk);
                    #1;
                end
            end
            lit_valid = 1'b1;
            lit_data  = base + 8'(i);
            ok = 1'b0;
            for (int w = 0; w < 50 && !ok; w++) begin
                @(negedge clk);
                if (lit_ready) ok = 1'b1;
            end
            @(posedge clk);
            #1;
            lit_valid = 1'b0;
            if (!ok) begin
                checkOutput("lit_timeout", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic waitIdle();
        bit idle;
        idle = 1'b0;
        for (int w = 0; w < 3000 && !idle; w++) begin
            @(negedge clk);
            if (!busy) idle = 1'b1;
        end
        if (!idle) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic compareStream(input string tag);
        checkOutput({tag, "_len"}, gotQ.size(), expQ.size());
        for (int i = 0; i < expQ.size() && i < gotQ.size(); i++) begin
            checkOutput($sformatf("%s_byte%0d", tag, i), 32'(gotQ[i][7:0]), 32'(expQ[i]));
            checkOutput($sformatf("%s_last%0d", tag, i), 32'(gotQ[i][8]), (i == expLastIdx) ? 32'd1 : 32'd0);
        end
    endtask

    // Basic sequence, reused after error and reset tests.
    task automatic runBasic(input string tag);
        gotQ.delete();
        expQ.delete();
        expQ.push_back(8'h30);
        addLits(3, 8'h41);
        expQ.push_back(8'h03);
        expQ.push_back(8'h00);
        expLastIdx = -1;
        applyStimulus(3, 4, 3, 1'b0, 3, 8'h41);
        waitIdle();
        compareStream(tag);
    endtask

    // Nibble-saturation sequence: lit 15, match 19, offset 0x1234.
    task automatic runSaturation(input string tag);
        gotQ.delete();
        expQ.delete();
        expQ.push_back(8'hFF);
        expQ.push_back(8'h00);
        addLits(15, 8'h60);
        expQ.push_back(8'h34);
        expQ.push_back(8'h12);
        expQ.push_back(8'h00);
        expLastIdx = -1;
        applyStimulus(15, 19, 16'h1234, 1'b0, 15, 8'h60);
        waitIdle();
        compareStream(tag);
    endtask

    // Main sequence of directed tests.
    initial begin
        // Reset state, with a command already offered.
        seq_valid = 1'b1;
        lit_len   = 16'd3;
        match_len = 16'd4;
        offset    = 16'd3;
        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data",  32'(out_data),  32'h00);
        checkOutput("rst_out_last",  32'(out_last),  32'd0);
        checkOutput("rst_busy",      32'(busy),      32'd0);
        checkOutput("rst_err",       32'(err),       32'd0);
        checkOutput("rst_seq_ready", 32'(seq_ready), 32'd0);
        checkOutput("rst_lit_ready", 32'(lit_ready), 32'd0);
        seq_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        runBasic("basic");
        runSaturation("sat");

        // Long literal run: 270 = 15 + 255 + 0.
        gotQ.delete();
        expQ.delete();
        expQ.push_back(8'hF0);
        expQ.push_back(8'hFF);
        expQ.push_back(8'h00);
        addLits(270, 8'h00);
        expQ.push_back(8'h01);
        expQ.push_back(8'h00);
        expLastIdx = -1;
        applyStimulus(270, 4, 1, 1'b0, 270, 8'h00);
        waitIdle();
        compareStream("long");

        // Last sequence with no literals: a lone 8'h00 token marked last.
        gotQ.delete();
        expQ.delete();
        expQ.push_back(8'h00);
        expLastIdx = 0;
        applyStimulus(0, 0, 0, 1'b1, 0, 8'h00);
        waitIdle();
        compareStream("last0");

        // Last sequence with 5 literals: last only on the 5th literal.
        gotQ.delete();
        expQ.delete();
        expQ.push_back(8'h50);
        addLits(5, 8'hA0);
        expLastIdx = 5;
        applyStimulus(5, 0, 0, 1'b1, 5, 8'hA0);
        waitIdle();
        compareStream("last5");

        // Saturation case again under toggling out_ready and gapped literals.
        bpMode  = 1'b1;
        gapMode = 1'b1;
        runSaturation("bp");
        bpMode  = 1'b0;
        gapMode = 1'b0;
        repeat (2) @(posedge clk);

        // Illegal commands: short match, zero offset, last with a match.
        for (int k = 0; k < 3; k++) begin
            gotQ.delete();
            errCycles = 0;
            case (k)
                0:       applyStimulus(0, 3, 3, 1'b0, 0, 8'h00);
                1:       applyStimulus(2, 4, 0, 1'b0, 0, 8'h00);
                default: applyStimulus(0, 4, 0, 1'b1, 0, 8'h00);
            endcase
            repeat (4) @(negedge clk);
            checkOutput($sformatf("err%0d_pulse_cycles", k), errCycles, 32'd1);
            checkOutput($sformatf("err%0d_bytes_out", k), gotQ.size(), 32'd0);
        end
        runBasic("after_err");

        // Reset in the middle of the literal phase.
        gotQ.delete();
        applyStimulus(10, 4, 2, 1'b0, 3, 8'h10);
        checkOutput("mid_busy_before", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_busy",      32'(busy),      32'd0);
        checkOutput("mid_rst_lit_ready", 32'(lit_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        runBasic("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

    // Global guard so a wedged run still terminates.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/yonga_lz4_sequence_encoder.md
Name: yonga_lz4_sequence_encoder

Overview:
- Serializes LZ4 sequences into a standard LZ4 block byte stream. This is the encode-side counterpart of the existing LZ4 decoder's sequence parser.
- An upstream match finder supplies one command per sequence (literal length, match length, offset) plus a separate literal byte stream.
- The block emits token, literal-length extension bytes, literals, little-endian offset and match-length extension bytes.
- The output byte stream feeds the UART TX path or the Wishbone readback buffer.

Parameters:
- LEN_W, 16, width of lit_len and match_len; lengths are unsigned.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- seq_valid  in  1  command valid
- seq_ready  out  1  command accepted when seq_valid&&seq_ready
- lit_len  in  LEN_W  literal count of sequence
- match_len  in  LEN_W  actual match length (>=4), or 0 for last sequence
- offset  in  16  match offset, 1..65535
- seq_last  in  1  final sequence of block (literals only)
- lit_valid  in  1  literal byte valid
- lit_ready  out  1  literal byte consumed when lit_valid&&lit_ready
- lit_data  in  8  literal byte
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts byte
- out_data  out  8  output byte
- out_last  out  1  final byte of block
- busy  out  1  state != IDLE or out_valid
- err  out  1  one-cycle pulse on illegal command

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all counters 0.
  - seq_ready=0 and lit_ready=0 while in reset.
  - out_valid=0, out_data=8'h00, out_last=0, busy=0, err=0.
- Output register:
  - Single output register; load_ok = !out_valid || out_ready.
  - out_data/out_last are held stable while out_valid && !out_ready.
- seq_ready=1 only in IDLE with load_ok. Command fields are latched on accept.
- The token appears on out_data the cycle after accept: one-cycle latency.
- Token byte:
  - high nibble = min(lit_len,15).
  - low nibble = min(match_len-4,15); 0 when seq_last.
- Extension encoding (length L >= 15):
  - rem = L-15.
  - While rem >= 255: emit 8'hFF, rem -= 255.
  - Then emit rem, including 8'h00 when rem == 0.
  - Example: L=15 gives one 8'h00; L=270 gives 8'hFF then 8'h00.
- States: IDLE -> TOKEN -> [LIT_EXT] -> [LITS] -> OFF_LO -> OFF_HI -> [ML_EXT] -> IDLE.
  - LIT_EXT is entered only if lit_len >= 15.
  - LITS is skipped if lit_len == 0.
  - ML_EXT is entered only if match_len-4 >= 15.
  - With seq_last, the path after LITS goes directly to IDLE; no offset or ML bytes.
- LITS:
  - lit_ready = load_ok, which is a combinational path from out_ready.
  - Each consumed byte is loaded to out_data and decrements the remaining count.
  - If lit_valid=0, no output is loaded and the block waits indefinitely.
- Offset is emitted low byte first, then high byte.
- out_last:
  - Set on the last literal byte of a seq_last command.
  - Set on the token itself if seq_last && lit_len == 0 (token 8'h00).
  - Never set for non-last sequences.
- Illegal command, checked at accept:
  - Cases: (!seq_last && (match_len < 4 || offset == 0)) or (seq_last && match_len != 0).
  - Response: command is consumed, err=1 for one cycle, nothing emitted, state stays IDLE.
- Counters:
  - Extension remainders are LEN_W bits; no wrap is possible since each is decremented only while >= 255.
  - lit_len=2^LEN_W-1 is legal.
- Reset mid-sequence: everything is discarded immediately, with no partial-byte completion.

Decomposition:
- Shared package yonga_lz4_pkg holds:
  - state enum;
  - MIN_MATCH=4;
  - NIBBLE_MAX=15;
  - EXT_BYTE_MAX=255.
- One natural sub-module: yonga_lz4_len_ext_gen.
  - Loads L-15 and steps on a load_ok strobe.
  - Outputs the current extension byte and a done flag.
  - It is instantiated twice, once for literal length and once for match length.

Test Plan:
- Basic sequence: lit_len=3 "ABC", match_len=4, offset=3, out_ready=1 -> out bytes 30 41 42 43 03 00; out_last=0 throughout.
- Nibble saturation: lit_len=15, match_len=19, offset=0x1234 -> FF 00, 15 literals, 34 12, 00.
- Long literal run: lit_len=270, match_len=4, offset=1 -> F0 FF 00, 270 literals, 01 00; no extra ML byte.
- Last sequences:
  - seq_last, lit_len=0 -> single 00 with out_last=1.
  - seq_last, lit_len=5 -> 50 plus 5 literals, out_last only on the 5th literal.
- Backpressure: test 2 repeated with out_ready toggling 1/0 and lit_valid randomly gapped -> byte stream identical to test 2, no drops or duplicates, out_data stable while stalled.
- Error and reset:
  - match_len=3, non-last -> err pulses 1 cycle, out_valid stays 0, next good command encodes correctly.
  - rst_n=0 mid-LITS -> out_valid=0 and busy=0 immediately, then IDLE.
